// File: rtl/nios_project_button_ctrl.sv
// Avalon-MM push-button controller: synchroniser, per-bit debouncer, edge capture and
// a maskable level interrupt for the Nios II.
module nios_project_button_ctrl #(
  parameter int              WIDTH      = 2,
  parameter logic [WIDTH-1:0] IDLE_LEVEL = 2'b11,
  parameter bit              EDGE_SEL   = 1'b0,
  parameter logic [15:0]     DB_DEFAULT = 16'd50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [15:0]      cnt_q [WIDTH];
  logic [15:0]      cnt_d [WIDTH];
  logic [15:0]      dbperiod_q, dbperiod_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] edge_set, edge_clr;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata[31:16];

  // Debounce: a new level is accepted after dbperiod+1 consecutive differing samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == dbperiod_q) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  // Edges come from the accept decision so capture lands on the same edge as stable.
  always_comb begin
    if (EDGE_SEL) edge_set = ~stable_q & stable_d;
    else          edge_set = stable_q & ~stable_d;
  end

  always_comb begin
    dbperiod_d = dbperiod_q;
    irqmask_d  = irqmask_q;
    edge_clr   = '0;
    if (wr_en) begin
      case (address)
        2'd1:    dbperiod_d = writedata[15:0];
        2'd2:    irqmask_d  = writedata[WIDTH-1:0];
        2'd3:    edge_clr   = writedata[WIDTH-1:0];
        default: ;
      endcase
    end
    // A capture in the same cycle as a clear wins.
    edgecap_d = (edgecap_q & ~edge_clr) | edge_set;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = stable_q;
      2'd1:    readdata_d[15:0]      = dbperiod_q;
      2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
      default: readdata_d[WIDTH-1:0] = edgecap_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= IDLE_LEVEL;
      sync2_q    <= IDLE_LEVEL;
      stable_q   <= IDLE_LEVEL;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      dbperiod_q <= DB_DEFAULT;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      dbperiod_q <= dbperiod_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= |(edgecap_q & irqmask_q);
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
